// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared constants for the fixed-duty PWM generator. Duty
//            thresholds for the five compare outputs, the last phase value
//            before wrap, and the SpeedControl encodings.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package pwm_pkg;

  // Compare thresholds; an output is high while the phase is below its value.
  localparam logic [7:0] DUTY_255 = 8'd255;
  localparam logic [7:0] DUTY_250 = 8'd250;
  localparam logic [7:0] DUTY_220 = 8'd220;
  localparam logic [7:0] DUTY_150 = 8'd150;
  localparam logic [7:0] DUTY_0   = 8'd0;

  // Last phase value; the counter wraps from here to 0, giving 255 steps.
  localparam logic [7:0] PWM_MAX  = 8'd254;

  // Carrier-frequency select encodings.
  typedef enum logic [1:0] {
    SPD_00 = 2'b00,
    SPD_01 = 2'b01,
    SPD_10 = 2'b10,
    SPD_11 = 2'b11
  } spd_e;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : pwm_prescaler
// Purpose  : Clock prescaler producing a one-clk phase-step tick every
//            div_i clocks.
// Ports    : clk    in   1   system clock
//            rst    in   1   synchronous active-high reset
//            div_i  in   16  divide ratio (must be >= 1)
//            tick_o out  1   high in the clk during which the prescaler wraps
// Revision : 1.0  initial release
// ============================================================================
module pwm_prescaler (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] div_i,
  output logic        tick_o
);

  logic [15:0] pre_q;
  logic [15:0] pre_d;
  logic        w_wrap;

  // ">=" rather than "==": if div_i shrinks while pre_q is already past the
  // new terminal value, the prescaler wraps on the next clk instead of
  // running all the way round the 16-bit range.
  assign w_wrap = (pre_q >= (div_i - 16'd1));
  assign tick_o = w_wrap;

  always_comb begin
    pre_d = pre_q + 16'd1;
    if (w_wrap) begin
      pre_d = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= 16'd0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule : pwm_prescaler
`default_nettype wire

// File: rtl/pwm.sv
`default_nettype none
// ============================================================================
// Module   : pwm
// Purpose  : Fixed-duty PWM generator for the motor drivers. Five waveforms
//            (duty 255, 250, 220, 150 and 0 out of 255) share one 8-bit
//            phase counter; SpeedControl picks the carrier via a prescaler.
// Ports    : clk           in   1  system clock
//            rst           in   1  synchronous active-high reset
//            SpeedControl  in   2  carrier select (DIV_0..DIV_3)
//            pwm_255       out  1  duty 255/255 (high outside reset)
//            pwm_250       out  1  duty 250/255
//            pwm_220       out  1  duty 220/255
//            pwm_150       out  1  duty 150/255
//            pwm_0         out  1  duty 0/255 (always low)
// Revision : 1.0  initial release
// ============================================================================
module pwm
  import pwm_pkg::*;
#(
  parameter int unsigned DIV_0 = 196,
  parameter int unsigned DIV_1 = 98,
  parameter int unsigned DIV_2 = 49,
  parameter int unsigned DIV_3 = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] SpeedControl,
  output logic       pwm_255,
  output logic       pwm_250,
  output logic       pwm_220,
  output logic       pwm_150,
  output logic       pwm_0
);

  localparam logic [15:0] C_DIV_0 = 16'(DIV_0);
  localparam logic [15:0] C_DIV_1 = 16'(DIV_1);
  localparam logic [15:0] C_DIV_2 = 16'(DIV_2);
  localparam logic [15:0] C_DIV_3 = 16'(DIV_3);

  logic [15:0] w_div;
  logic        w_tick;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic [4:0]  out_q;
  logic [4:0]  out_d;

  // SpeedControl is a quasi-static same-domain control, so it feeds the
  // divide mux directly without a synchronizer.
  always_comb begin
    w_div = C_DIV_0;
    case (spd_e'(SpeedControl))
      SPD_00:  w_div = C_DIV_0;
      SPD_01:  w_div = C_DIV_1;
      SPD_10:  w_div = C_DIV_2;
      SPD_11:  w_div = C_DIV_3;
      default: w_div = C_DIV_0;
    endcase
  end

  pwm_prescaler u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .div_i  (w_div),
    .tick_o (w_tick)
  );

  // Phase counter: 255 steps per period (0..PWM_MAX).
  always_comb begin
    cnt_d = cnt_q;
    if (w_tick) begin
      cnt_d = (cnt_q == PWM_MAX) ? 8'd0 : cnt_q + 8'd1;
    end
  end

  // Compares are taken on the current phase and registered, so every
  // output lags cnt_q by exactly one clk and is glitch-free.
  always_comb begin
    out_d[4] = (cnt_q < DUTY_255);
    out_d[3] = (cnt_q < DUTY_250);
    out_d[2] = (cnt_q < DUTY_220);
    out_d[1] = (cnt_q < DUTY_150);
    out_d[0] = (cnt_q < DUTY_0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
      out_q <= 5'd0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign pwm_255 = out_q[4];
  assign pwm_250 = out_q[3];
  assign pwm_220 = out_q[2];
  assign pwm_150 = out_q[1];
  assign pwm_0   = out_q[0];

endmodule : pwm
`default_nettype wire

// File: tb/tb_pwm.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm
// Purpose  : Directed self-checking bench for pwm with short divides
//            (DIV_0=1, DIV_1=2, DIV_2=3, DIV_3=4). Outputs are sampled on
//            the falling clock edge; inputs are changed there too.
// Revision : 1.0  initial release
// ============================================================================
module tb_pwm;

  logic       clk;
  logic       rst;
  logic [1:0] SpeedControl;
  logic       pwm_255;
  logic       pwm_250;
  logic       pwm_220;
  logic       pwm_150;
  logic       pwm_0;
  logic [4:0] w_out;

  int n_total;
  int n_pass;
  int c_255;
  int c_250;
  int c_220;
  int c_150;
  int c_0;
  int c_x;
  logic r_last150;

  assign w_out = {pwm_255, pwm_250, pwm_220, pwm_150, pwm_0};

  pwm #(
    .DIV_0 (1),
    .DIV_1 (2),
    .DIV_2 (3),
    .DIV_3 (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .SpeedControl (SpeedControl),
    .pwm_255      (pwm_255),
    .pwm_250      (pwm_250),
    .pwm_220      (pwm_220),
    .pwm_150      (pwm_150),
    .pwm_0        (pwm_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Accumulate high-sample counts starting at the current sample, for len
  // samples; returns positioned on the sample that follows the window.
  task automatic count_window(input int len);
    c_255 = 0; c_250 = 0; c_220 = 0; c_150 = 0; c_0 = 0; c_x = 0;
    r_last150 = 1'b0;
    for (int i = 0; i < len; i++) begin
      if ($isunknown(w_out)) c_x++;
      if (pwm_255 === 1'b1) c_255++;
      if (pwm_250 === 1'b1) c_250++;
      if (pwm_220 === 1'b1) c_220++;
      if (pwm_150 === 1'b1) c_150++;
      if (pwm_0   === 1'b1) c_0++;
      r_last150 = pwm_150;
      step();
    end
  endtask

  // Advance to the first sample where pwm_150 has just risen (phase 0).
  task automatic sync_rise(input string tag);
    logic prev;
    bit   found;
    found = 1'b0;
    prev  = pwm_150;
    for (int i = 0; i < 4000; i++) begin
      step();
      if (prev === 1'b0 && pwm_150 === 1'b1) begin
        found = 1'b1;
        break;
      end
      prev = pwm_150;
    end
    if (!found) chk({tag, "_sync_timeout"}, 32'd0, 32'd1);
  endtask

  // One full period from a phase-0 sample: high times N*div and the next
  // rise of pwm_150 exactly 255*div clks later.
  task automatic measure(input string tag, input int div, input bit do_sync);
    if (do_sync) sync_rise(tag);
    count_window(255 * div);
    chk({tag, "_hi255"}, c_255, 255 * div);
    chk({tag, "_hi250"}, c_250, 250 * div);
    chk({tag, "_hi220"}, c_220, 220 * div);
    chk({tag, "_hi150"}, c_150, 150 * div);
    chk({tag, "_hi0"},   c_0,   0);
    chk({tag, "_period"}, {31'd0, (r_last150 === 1'b0) && (pwm_150 === 1'b1)}, 32'd1);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    SpeedControl = 2'b00;

    // 1: reset held 3 clks, then first clk after release.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_hold", {27'd0, w_out}, 32'd0);
    end
    rst = 1'b0;
    step();
    chk("rst_release", {27'd0, w_out}, 32'b11110);

    // 2: div 1, two periods.
    measure("div1_a", 1, 1'b1);
    measure("div1_b", 1, 1'b0);

    // 3: div 4.
    SpeedControl = 2'b11;
    measure("div4", 4, 1'b1);

    // 4: at a phase-0 sample with div 4, prescaler is at 1; two clks later
    // it is at 3. Switching to div 1 then wraps it and the phase advances
    // every clk, so outputs see phase 0 once more before stepping.
    step();
    step();
    SpeedControl = 2'b00;
    step();
    count_window(254);
    chk("sw_hi255", c_255, 254);
    chk("sw_hi250", c_250, 250);
    chk("sw_hi220", c_220, 220);
    chk("sw_hi150", c_150, 150);
    chk("sw_hi0",   c_0,   0);
    chk("sw_nox",   c_x,   0);

    // 5: div 2; phase 200 is reached 399 clks after a phase-0 sample.
    SpeedControl = 2'b01;
    measure("div2", 2, 1'b1);
    for (int i = 0; i < 399; i++) step();
    rst = 1'b1;
    step();
    chk("rst_mid", {27'd0, w_out}, 32'd0);
    rst = 1'b0;
    step();
    chk("rst_mid_rel", {27'd0, w_out}, 32'b11110);
    count_window(510);
    chk("fresh_hi220", c_220, 440);
    chk("fresh_hi150", c_150, 300);
    chk("fresh_hi250", c_250, 500);
    chk("fresh_hi255", c_255, 510);
    chk("fresh_hi0",   c_0,   0);

    // 6: setting sequence, three back-to-back periods each.
    begin
      logic [1:0] seq [7];
      int         dv  [4];
      seq = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b10};
      dv  = '{1, 2, 3, 4};
      for (int s = 0; s < 7; s++) begin
        SpeedControl = seq[s];
        for (int p = 0; p < 3; p++) begin
          measure($sformatf("seq%0d_p%0d", s, p), dv[seq[s]], (p == 0));
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_pwm
`default_nettype wire
